// File: rtl/pe_loader.sv
// Stream loader for a convolution PE. It buffers one tile of weights and activations,
// bursts them to the PE, then sequences the compute passes and returns the psum results.
module pe_loader #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned KERNEL_SIZE = 3,
  parameter int unsigned ACT_SIZE    = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] filt_in,
  output logic                  load_en_wght,
  output logic [DATA_WIDTH-1:0] act_in,
  output logic                  load_en_act,
  output logic                  start,
  input  logic                  load_done,
  input  logic                  compute_done,
  input  logic [DATA_WIDTH-1:0] pe_out,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy
);

  localparam int unsigned W     = KERNEL_SIZE * KERNEL_SIZE;
  localparam int unsigned A     = ACT_SIZE * ACT_SIZE;
  localparam int unsigned N     = W + A;
  localparam int unsigned CW    = $clog2(N + 1);
  localparam int unsigned ITERS = ACT_SIZE - KERNEL_SIZE + 1;
  localparam int unsigned IW    = $clog2(ITERS + 1);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_FILL    = 4'd1;
  localparam logic [3:0] S_LOAD_W  = 4'd2;
  localparam logic [3:0] S_WAIT_LW = 4'd3;
  localparam logic [3:0] S_LOAD_A  = 4'd4;
  localparam logic [3:0] S_WAIT_LA = 4'd5;
  localparam logic [3:0] S_START   = 4'd6;
  localparam logic [3:0] S_WAIT_C  = 4'd7;
  localparam logic [3:0] S_OUT     = 4'd8;

  logic [3:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         iter_q, iter_d;
  logic [DATA_WIDTH-1:0] filt_in_q, filt_in_d;
  logic [DATA_WIDTH-1:0] act_in_q, act_in_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  load_en_wght_q, load_en_wght_d;
  logic                  load_en_act_q, load_en_act_d;
  logic                  start_q, start_d;
  logic                  out_valid_q, out_valid_d;
  logic                  busy_q, busy_d;
  logic                  in_ready_q, in_ready_d;
  logic                  mem_we;
  logic [CW-1:0]         mem_idx;
  logic                  beat;
  logic [DATA_WIDTH-1:0] mem_q [N];

  assign beat = in_valid & in_ready_q;

  // Next-state and registered-output computation; outputs trail the state by one cycle.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    iter_d         = iter_q;
    filt_in_d      = filt_in_q;
    act_in_d       = act_in_q;
    out_data_d     = out_data_q;
    out_valid_d    = out_valid_q;
    load_en_wght_d = 1'b0;
    load_en_act_d  = 1'b0;
    start_d        = 1'b0;
    mem_we         = 1'b0;
    mem_idx        = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (beat) begin
          mem_we  = 1'b1;
          mem_idx = '0;
          cnt_d   = CW'(1);
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        if (beat) begin
          mem_we = 1'b1;
          if (cnt_q == CW'(N - 1)) begin
            cnt_d   = '0;
            state_d = S_LOAD_W;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_LOAD_W: begin
        filt_in_d      = mem_q[cnt_q];
        load_en_wght_d = (cnt_q == '0);
        if (cnt_q == CW'(W - 1)) begin
          cnt_d   = '0;
          state_d = S_WAIT_LW;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WAIT_LW: begin
        if (load_done) state_d = S_LOAD_A;
      end
      S_LOAD_A: begin
        act_in_d      = mem_q[CW'(W) + cnt_q];
        load_en_act_d = (cnt_q == '0);
        if (cnt_q == CW'(A - 1)) begin
          cnt_d   = '0;
          state_d = S_WAIT_LA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WAIT_LA: begin
        if (load_done) begin
          iter_d  = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        start_d = 1'b1;
        state_d = S_WAIT_C;
      end
      S_WAIT_C: begin
        if (compute_done) begin
          out_data_d  = pe_out;
          out_valid_d = 1'b1;
          state_d     = S_OUT;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (iter_q == IW'(ITERS - 1)) begin
            iter_d  = '0;
            state_d = S_IDLE;
          end else begin
            iter_d  = iter_q + IW'(1);
            state_d = S_START;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d     = (state_d != S_IDLE);
    in_ready_d = (state_d == S_IDLE) || (state_d == S_FILL);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      iter_q         <= '0;
      filt_in_q      <= '0;
      act_in_q       <= '0;
      out_data_q     <= '0;
      load_en_wght_q <= 1'b0;
      load_en_act_q  <= 1'b0;
      start_q        <= 1'b0;
      out_valid_q    <= 1'b0;
      busy_q         <= 1'b0;
      in_ready_q     <= 1'b1;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      iter_q         <= iter_d;
      filt_in_q      <= filt_in_d;
      act_in_q       <= act_in_d;
      out_data_q     <= out_data_d;
      load_en_wght_q <= load_en_wght_d;
      load_en_act_q  <= load_en_act_d;
      start_q        <= start_d;
      out_valid_q    <= out_valid_d;
      busy_q         <= busy_d;
      in_ready_q     <= in_ready_d;
    end
  end

  // Tile storage is deliberately not reset; every tile overwrites it completely in FILL.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_idx] <= in_data;
  end

  assign in_ready     = in_ready_q;
  assign filt_in      = filt_in_q;
  assign load_en_wght = load_en_wght_q;
  assign act_in       = act_in_q;
  assign load_en_act  = load_en_act_q;
  assign start        = start_q;
  assign out_data     = out_data_q;
  assign out_valid    = out_valid_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_pe_loader.sv
// Scoreboard bench for pe_loader: stimulus pushes expected bursts/results,
// monitors pop and compare as the DUT presents them; a small PE model answers handshakes.
module tb_pe_loader;
  localparam int unsigned DW  = 16;
  localparam int unsigned W   = 9;
  localparam int unsigned A   = 25;
  localparam int unsigned NIT = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] filt_in;
  logic          load_en_wght;
  logic [DW-1:0] act_in;
  logic          load_en_act;
  logic          start;
  logic          load_done;
  logic          compute_done;
  logic [DW-1:0] pe_out;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          busy;

  int errors = 0;
  int checks = 0;
  int nstart = 0;
  bit bp_first = 0;
  bit spur = 0;
  logic [DW-1:0] exp_w[$];
  logic [DW-1:0] exp_a[$];
  logic [DW-1:0] exp_o[$];

  always #5 clk = ~clk;

  pe_loader #(.DATA_WIDTH(DW), .KERNEL_SIZE(3), .ACT_SIZE(5)) dut (
    .clk(clk), .reset(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .filt_in(filt_in), .load_en_wght(load_en_wght),
    .act_in(act_in), .load_en_act(load_en_act),
    .start(start), .load_done(load_done), .compute_done(compute_done), .pe_out(pe_out),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Weight burst monitor: W gapless words, strobe only on the first.
  initial begin : wmon
    int wk;
    wk = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) wk = 0;
      else begin
        if (load_en_wght) begin
          if (wk != 0) chk("w_strobe_midburst", wk, 0);
          wk = W;
        end
        if (wk > 0) begin
          if (exp_w.size() == 0) chk("w_extra_word", 1, 0);
          else chk("filt_in", filt_in, exp_w.pop_front());
          wk--;
        end
      end
    end
  end

  // Activation burst monitor.
  initial begin : amon
    int ak;
    ak = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) ak = 0;
      else begin
        if (load_en_act) begin
          if (ak != 0) chk("a_strobe_midburst", ak, 0);
          ak = A;
        end
        if (ak > 0) begin
          if (exp_a.size() == 0) chk("a_extra_word", 1, 0);
          else chk("act_in", act_in, exp_a.pop_front());
          ak--;
        end
      end
    end
  end

  // Result and start monitor.
  initial begin : omon
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (out_valid && out_ready) begin
          if (exp_o.size() == 0) chk("out_extra", 1, 0);
          else chk("out_data", out_data, exp_o.pop_front());
        end
        if (start) begin
          nstart++;
          chk("start_alone", {30'd0, load_en_wght, load_en_act}, 0);
        end
      end
    end
  end

  // PE model: load_done 2 cycles after each burst, compute_done 4 cycles after start.
  initial begin : pe
    int ld_t;
    int cd_t;
    int it;
    ld_t = 0; cd_t = 0; it = 0;
    load_done = 1'b0; compute_done = 1'b0; pe_out = '0;
    forever begin
      @(posedge clk); #1;
      load_done = 1'b0;
      compute_done = 1'b0;
      if (!rst_n) begin
        ld_t = 0; cd_t = 0; it = 0;
      end else begin
        if (ld_t > 0) begin
          ld_t--;
          if (ld_t == 0) load_done = 1'b1;
        end
        if (cd_t > 0) begin
          cd_t--;
          if (cd_t == 0) begin
            compute_done = 1'b1;
            pe_out = DW'(32'h0100 + it);
            it++;
          end else if (spur && cd_t == 2) begin
            load_done = 1'b1;
          end
        end
        if (load_en_wght) begin
          ld_t = W + 1;
          it = 0;
        end
        if (load_en_act) begin
          ld_t = A + 1;
          if (spur) compute_done = 1'b1;
        end
        if (start) cd_t = 4;
      end
    end
  end

  // Result sink with optional backpressure on the first result of a tile.
  initial begin : sink
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (bp_first && out_valid && rst_n) begin
        bp_first = 0;
        out_ready = 1'b0;
        repeat (10) begin
          @(posedge clk); #1;
          chk("bp_hold_valid", {31'd0, out_valid}, 1);
          chk("bp_hold_data", {16'd0, out_data}, 32'h0100);
          chk("bp_no_start", {31'd0, start}, 0);
        end
        out_ready = 1'b1;
      end
    end
  end

  task automatic send_tile(input logic [DW-1:0] wb, input logic [DW-1:0] ab, input bit gap);
    logic [DW-1:0] v;
    bit acc;
    int guard;
    for (int k = 0; k < int'(NIT); k++) exp_o.push_back(DW'(32'h0100 + k));
    for (int i = 0; i < int'(W + A); i++) begin
      v = (i < int'(W)) ? wb + DW'(i) : ab + DW'(i - int'(W));
      if (i < int'(W)) exp_w.push_back(v);
      else exp_a.push_back(v);
      acc = 0;
      guard = 0;
      while (!acc) begin
        @(negedge clk);
        in_valid = 1'b1;
        in_data = v;
        acc = in_ready;
        @(posedge clk);
        guard++;
        if (guard > 3000) begin
          chk("send_timeout", 1, 0);
          in_valid = 1'b0;
          return;
        end
      end
      if (gap) begin
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int nst);
    bit done;
    done = 0;
    for (int g = 0; g < 4000 && !done; g++) begin
      @(negedge clk);
      done = (exp_o.size() == 0) && (exp_w.size() == 0) && (exp_a.size() == 0) && !busy;
    end
    if (!done) chk("tile_timeout", 1, 0);
    chk("start_count", nstart, nst);
    chk("busy_idle", {31'd0, busy}, 0);
    chk("in_ready_idle", {31'd0, in_ready}, 1);
    nstart = 0;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_filt_in"}, {16'd0, filt_in}, 0);
    chk({tag, "_act_in"}, {16'd0, act_in}, 0);
    chk({tag, "_out_data"}, {16'd0, out_data}, 0);
    chk({tag, "_strobes"}, {28'd0, load_en_wght, load_en_act, start, out_valid}, 0);
    chk({tag, "_busy"}, {31'd0, busy}, 0);
  endtask

  initial begin : main
    int g;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 1);

    // Contiguous tile, then the same tile with alternating input gaps.
    send_tile(16'd1, 16'd1, 1'b0);
    wait_done(NIT);
    send_tile(16'd1, 16'd1, 1'b1);
    wait_done(NIT);

    // First result held under backpressure.
    bp_first = 1;
    send_tile(16'd1, 16'd1, 1'b0);
    wait_done(NIT);

    // Strobes arriving in states that must ignore them.
    spur = 1;
    send_tile(16'd1, 16'd1, 1'b0);
    wait_done(NIT);
    spur = 0;

    // Abort in the middle of the activation burst.
    send_tile(16'h0010, 16'h0020, 1'b0);
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!load_en_act && g < 1000);
    if (g >= 1000) chk("wait_load_a_timeout", 1, 0);
    repeat (12) @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_zero_outputs("mid_rst");
    exp_w.delete();
    exp_a.delete();
    exp_o.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    nstart = 0;
    @(negedge clk);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 1);
    send_tile(16'd1, 16'd1, 1'b0);
    wait_done(NIT);

    // Back-to-back tiles with distinct contents.
    send_tile(16'h0200, 16'h0300, 1'b0);
    send_tile(16'h0400, 16'h0500, 1'b0);
    wait_done(2 * NIT);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pe_loader.md
PE_LOADER -- requirements
Module: pe_loader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: word width of all data ports.
REQ-002 SHALL have parameter KERNEL_SIZE, default 3: filter is KERNEL_SIZE**2 words.
REQ-003 SHALL have parameter ACT_SIZE, default 5: activation tile is ACT_SIZE**2 words.
REQ-004 SHALL have port clk  input  1: sole clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1: asynchronous, active-low reset.
REQ-006 SHALL have ports in_data input DATA_WIDTH, in_valid input 1, in_ready output 1: source stream, weights first then activations.
REQ-007 SHALL have ports filt_in output DATA_WIDTH, load_en_wght output 1: weight burst to PE.
REQ-008 SHALL have ports act_in output DATA_WIDTH, load_en_act output 1: activation burst to PE.
REQ-009 SHALL have ports start output 1, load_done input 1, compute_done input 1, pe_out input DATA_WIDTH: PE control/result.
REQ-010 SHALL have ports out_data output DATA_WIDTH, out_valid output 1, out_ready input 1: psum result stream.
REQ-011 SHALL have port busy output 1: high in every state except IDLE.

Function
REQ-012 All outputs SHALL be registered; PE-facing outputs change only on clk rising edge.
REQ-013 FSM states SHALL be IDLE, FILL, LOAD_W, WAIT_LW, LOAD_A, WAIT_LA, START, WAIT_C, OUT.
REQ-014 IDLE->FILL when in_valid=1; in_ready=1 in IDLE and FILL only.
REQ-015 FILL: each in_valid&in_ready beat SHALL write buffer[cnt], cnt++; W=KERNEL_SIZE**2 weights then A=ACT_SIZE**2 activations; after beat W+A-1 -> LOAD_W, cnt=0.
REQ-016 LOAD_W: for W consecutive cycles filt_in=buffer[k], k=0..W-1, no gaps; load_en_wght=1 only in k=0 cycle; then -> WAIT_LW.
REQ-017 WAIT_LW: all PE strobes 0; on load_done=1 -> LOAD_A.
REQ-018 LOAD_A: for A consecutive cycles act_in=buffer[W+k]; load_en_act=1 only in k=0 cycle; then -> WAIT_LA.
REQ-019 WAIT_LA: on load_done=1 -> START, iter=0.
REQ-020 START: start=1 for exactly one cycle -> WAIT_C; start SHALL never coincide with load_en_wght/load_en_act.
REQ-021 WAIT_C: on compute_done=1 capture pe_out into out_data, out_valid=1 -> OUT.
REQ-022 OUT: hold out_data/out_valid stable until out_ready=1; on accept out_valid=0, iter++; iter==ACT_SIZE-KERNEL_SIZE+1 -> IDLE else -> START.
REQ-023 Exactly ACT_SIZE-KERNEL_SIZE+1 start pulses SHALL be issued per tile; never an extra one.
REQ-024 load_done/compute_done asserted in states other than WAIT_LW/WAIT_LA/WAIT_C SHALL be ignored.
REQ-025 in_valid while not in IDLE/FILL SHALL not be consumed (in_ready=0).
REQ-026 Gaps in in_valid during FILL SHALL stall cnt without loss; cnt width ceil(log2(W+A+1)).
REQ-027 filt_in/act_in hold last driven value outside bursts; values outside bursts are don't-care to PE.

Reset
REQ-028 reset=0 SHALL immediately force state=IDLE, cnt=0, iter=0, all strobes, start, out_valid, busy =0, filt_in=act_in=out_data=0, in_ready=1 after release.
REQ-029 Reset mid-burst or mid-compute SHALL abort the tile; buffer contents need not be cleared; next tile starts with a fresh FILL.

Verification
REQ-030 Full tile: send weights 1..9, acts 1..25 contiguously, PE model pulses load_done 2 cycles after each burst, compute_done 4 cycles after start with pe_out=0x0100+iter -> bursts of 9 and 25 gapless words, exactly 3 start pulses, out_data 0x0100,0x0101,0x0102.
REQ-031 Input gaps: in_valid toggled 1/0 every cycle -> identical bursts and outputs as REQ-030.
REQ-032 Backpressure: out_ready=0 for 10 cycles on first result -> out_data=0x0100 held, no second start until accept.
REQ-033 Spurious strobes: compute_done pulsed during LOAD_A, load_done during WAIT_C -> ignored, sequence unchanged.
REQ-034 Reset mid-LOAD_A (k=12) -> outputs zero same cycle, busy=0; new tile afterwards completes per REQ-030.
REQ-035 Back-to-back tiles: second tile on in_data right after first IDLE return -> second tile completes with its own values, no stale words.
